// File: rtl/occupancy_pkg.sv
// Shared types for the occupancy grid: map geometry, coordinate/address types and the
// streamer FSM state encoding.
package occupancy_pkg;

  localparam int unsigned CELL_WIDTH = 8;
  localparam int unsigned MAP_WIDTH  = 256;
  localparam int unsigned MAP_HEIGHT = 128;
  localparam int unsigned X_WIDTH    = $clog2(MAP_WIDTH);
  localparam int unsigned Y_WIDTH    = $clog2(MAP_HEIGHT);
  localparam int unsigned ADDR_WIDTH = $clog2(MAP_WIDTH * MAP_HEIGHT);

  typedef logic [CELL_WIDTH-1:0] cell_t;
  typedef logic [X_WIDTH-1:0]    coord_x_t;
  typedef logic [Y_WIDTH-1:0]    coord_y_t;
  typedef logic [ADDR_WIDTH-1:0] map_addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } streamer_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small circular FIFO with a valid/ready output side and an occupancy count.
// The writer is trusted never to push when full (it tracks credit through count).
module stream_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 9
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign push = in_valid;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/occupancy_map_streamer.sv
// Streams a rectangular window of the occupancy RAM out in row-major order over valid/ready.
// Define STREAMER_CHECKSUM_EN to add a 16-bit running checksum of the accepted cells.
module occupancy_map_streamer
  import occupancy_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      start,
  input  coord_x_t  win_x0,
  input  coord_y_t  win_y0,
  input  coord_x_t  win_x1,
  input  coord_y_t  win_y1,
  output logic      busy,
  output logic      done,
  output logic      error,
  output logic      mem_rd_en,
  output map_addr_t mem_addr,
  input  cell_t     mem_rd_data,
`ifdef STREAMER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output cell_t     out_data,
  output logic      out_valid,
  input  logic      out_ready,
  output logic      out_last
);

  streamer_state_t state_q, state_d;
  coord_x_t        x_q, x0_q, x1_q;
  coord_y_t        y_q, y1_q;
  logic            inflight_q, inflight_last_q, error_q;
  logic            window_ok, start_accept, last_addr, credit_ok, pop;
  logic [CELL_WIDTH:0]              fifo_out;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count;

  assign window_ok = (win_x0 <= win_x1) && (win_y0 <= win_y1) &&
                     (32'(win_x1) < MAP_WIDTH) && (32'(win_y1) < MAP_HEIGHT);
  assign start_accept = (state_q == StIdle) && start && window_ok;
  assign last_addr    = (x_q == x1_q) && (y_q == y1_q);
  assign pop          = out_valid && out_ready;

  // A beat leaving this cycle frees its slot, so occupancy-after-pop plus in-flight must fit.
  assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < (32'(FIFO_DEPTH) + 32'(pop));
  assign mem_rd_en = (state_q == StRead) && credit_ok;
  assign mem_addr  = map_addr_t'(32'(y_q) * MAP_WIDTH + 32'(x_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_accept) state_d = StRead;
      StRead:  if (mem_rd_en && last_addr) state_d = StDrain;
      StDrain: if (pop && out_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      x_q             <= '0;
      y_q             <= '0;
      x0_q            <= '0;
      x1_q            <= '0;
      y1_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      error_q         <= (state_q == StIdle) && start && !window_ok;
      inflight_q      <= mem_rd_en;
      inflight_last_q <= mem_rd_en && last_addr;
      if (start_accept) begin
        x_q  <= win_x0;
        y_q  <= win_y0;
        x0_q <= win_x0;
        x1_q <= win_x1;
        y1_q <= win_y1;
      end else if (mem_rd_en && !last_addr) begin
        if (x_q == x1_q) begin
          x_q <= x0_q;
          y_q <= y_q + coord_y_t'(1);
        end else begin
          x_q <= x_q + coord_x_t'(1);
        end
      end
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CELL_WIDTH + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   ({inflight_last_q, mem_rd_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign out_data = fifo_out[CELL_WIDTH-1:0];
  assign out_last = fifo_out[CELL_WIDTH];
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign error    = error_q;

`ifdef STREAMER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (start_accept) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + 16'(out_data);
    end
  end

  assign checksum = sum_q;
`endif

endmodule
